// File: rtl/sdram_host_bridge.sv
// rtl/sdram_host_bridge.sv - host request FIFO and strobe sequencer in front of the SDRAM controller
// Requests are replayed in order; reads return a one-cycle response, writes are posted.
module sdram_host_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_LEN = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic                        host_we,
  input  logic [19:0]                 host_addr,
  input  logic                        host_bhen,
  input  logic [15:0]                 host_wdata,
  output logic                        host_rvalid,
  output logic [15:0]                 host_rdata,
  output logic                        host_rerr,
  output logic                        mrdn,
  output logic                        mwrdn,
  output logic [19:0]                 mem_addr,
  output logic                        mem_bhen,
  inout  wire  [15:0]                 mem_data,
  input  logic                        rdyn,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        timeout_err,
  input  logic                        err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STROBE_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RESP} state_t;

  logic [37:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  state_t        r_state;
  logic [SW-1:0] r_stb_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_we;
  logic          r_drive;
  logic          r_mrdn;
  logic          r_mwrdn;
  logic [19:0]   r_addr;
  logic          r_bhen;
  logic [15:0]   r_wdata;
  logic          r_rvalid;
  logic [15:0]   r_rdata;
  logic          r_rerr;
  logic          r_terr;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_tmo;
  logic [37:0]   w_head;

  assign w_full  = (r_level == FULL_LVL);
  assign w_empty = (r_level == '0);
  assign w_push  = host_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !rdyn;
  assign w_head  = r_fifo[r_rptr];
  // A phase expires when the counter reaches its last value while still waiting.
  assign w_tmo   = (r_tmo_cnt == TMO_LAST) &&
                   (((r_state == S_WAIT_BUSY) && !rdyn) || ((r_state == S_WAIT_DONE) && rdyn));

  assign host_ready  = !w_full;
  assign fifo_level  = r_level;
  assign host_rvalid = r_rvalid;
  assign host_rdata  = r_rdata;
  assign host_rerr   = r_rerr;
  assign mrdn        = r_mrdn;
  assign mwrdn       = r_mwrdn;
  assign mem_addr    = r_addr;
  assign mem_bhen    = r_bhen;
  assign mem_data    = r_drive ? r_wdata : 16'hzzzz;
  assign timeout_err = r_terr;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {host_we, host_bhen, host_addr, host_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_stb_cnt <= '0;
      r_tmo_cnt <= '0;
      r_we      <= 1'b0;
      r_drive   <= 1'b0;
      r_mrdn    <= 1'b1;
      r_mwrdn   <= 1'b1;
      r_addr    <= '0;
      r_bhen    <= 1'b1;
      r_wdata   <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rerr    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_tmo) begin
        r_mrdn  <= 1'b1;
        r_mwrdn <= 1'b1;
        r_drive <= 1'b0;
        if (r_we) begin
          r_state <= S_IDLE;
        end else begin
          r_rvalid <= 1'b1;
          r_rdata  <= '0;
          r_rerr   <= 1'b1;
          r_state  <= S_RESP;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_we      <= w_head[37];
              r_bhen    <= w_head[36];
              r_addr    <= w_head[35:16];
              r_wdata   <= w_head[15:0];
              r_mwrdn   <= !w_head[37];
              r_mrdn    <= w_head[37];
              r_drive   <= w_head[37];
              r_stb_cnt <= STB_LAST;
              r_state   <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            if (r_stb_cnt == '0) begin
              r_mrdn    <= 1'b1;
              r_mwrdn   <= 1'b1;
              r_tmo_cnt <= '0;
              r_state   <= S_WAIT_BUSY;
            end else begin
              r_stb_cnt <= r_stb_cnt - SW'(1);
            end
          end
          S_WAIT_BUSY: begin
            if (rdyn) begin
              r_tmo_cnt <= '0;
              r_state   <= S_WAIT_DONE;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
          S_WAIT_DONE: begin
            if (!rdyn) begin
              if (r_we) begin
                r_drive <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_rvalid <= 1'b1;
                r_rdata  <= mem_data;
                r_rerr   <= 1'b0;
                r_state  <= S_RESP;
              end
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
          end
          S_RESP:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // A fresh timeout wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_terr <= 1'b0;
    else if (w_tmo)   r_terr <= 1'b1;
    else if (err_clr) r_terr <= 1'b0;
  end

endmodule

// File: doc/sdram_host_bridge.md
Name: sdram_host_bridge

Overview:
- Host-side front end of the SDRAM controller: accepts CPU-style read/write requests on a valid/ready port and buffers them in a small in-order FIFO.
- Replays each request to the controller through its active-low strobe interface (mrdn/mwrdn, Address, BHEn, shared 16-bit data bus), tracking completion via the controller's rdyn busy flag.
- Returns read data to the host as a one-cycle response pulse; writes are posted.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2).
- STROBE_LEN, 3, cycles mrdn/mwrdn held low; must cover the controller's 2-flop strobe synchroniser.
- TIMEOUT, 1024, max cycles waited in each rdyn phase before aborting.

Ports:
- clk  in  1  single clock, same clock as the controller's SDRAM_CLK domain.
- rst  in  1  reset, asynchronous, active-high.
- host_valid  in  1  request present.
- host_ready  out  1  FIFO can accept; equals !full.
- host_we  in  1  1=write, 0=read.
- host_addr  in  20  word address.
- host_bhen  in  1  byte-high enable, active low.
- host_wdata  in  16  write data.
- host_rvalid  out  1  one-cycle read-response pulse.
- host_rdata  out  16  read data, valid with host_rvalid.
- host_rerr  out  1  read aborted by timeout, valid with host_rvalid.
- mrdn  out  1  read strobe to controller, active low.
- mwrdn  out  1  write strobe to controller, active low.
- mem_addr  out  20  address to controller.
- mem_bhen  out  1  BHEn to controller.
- mem_data  inout  16  shared data bus to controller.
- rdyn  in  1  controller status: 1=busy, 0=ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- timeout_err  out  1  sticky flag, set on any timeout.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (async, active-high): FIFO emptied; state IDLE; mrdn=1, mwrdn=1; mem_data released to Z; mem_addr=0; mem_bhen=1; host_rvalid=0; host_rdata=0; host_rerr=0; timeout_err=0; fifo_level=0; host_ready=1 once rst deasserts. Reset mid-transaction aborts with no response.
- FIFO entry = {we, bhen, addr, wdata}, 38 bits, in-order.
- Push when host_valid && host_ready. host_ready is derived from full only, never from a same-cycle pop, so push while full is impossible.
- Simultaneous push and pop: level unchanged.
- Write and read pointers wrap modulo FIFO_DEPTH.
- An entry pushed into an empty FIFO is first poppable the following cycle.
- All controller-side outputs are registered.
- IDLE: when !empty && rdyn==0, pop the head entry, register mem_addr/mem_bhen (and wdata for writes), go to LAUNCH.
- LAUNCH:
  - Drive mrdn=0 (read) or mwrdn=0 (write) for exactly STROBE_LEN cycles, starting the cycle after the pop.
  - For writes, drive mem_data with wdata from the first LAUNCH cycle until leaving WAIT_DONE.
  - Strobes are never both low. Next state is WAIT_BUSY.
- WAIT_BUSY: strobe deasserted. Wait for rdyn==1, then go to WAIT_DONE. If TIMEOUT cycles elapse first, abort.
- WAIT_DONE: wait for rdyn==0, with the timeout counter reloaded on entry.
  - Read: capture mem_data on the first cycle rdyn==0 is sampled, go to RESP.
  - Write: release mem_data, go to IDLE.
- RESP: host_rvalid=1 for one cycle with captured host_rdata, host_rerr=0; then IDLE.
- Abort on timeout:
  - Set timeout_err and deassert strobes.
  - Read: go to RESP with host_rdata=0, host_rerr=1.
  - Write: go to IDLE and drop the write.
- timeout_err: set has priority over err_clr in the same cycle.
- Back-to-back: minimum gap from WAIT_DONE exit to the next pop is 1 cycle (the IDLE evaluation).
- Read responses are returned in request order.
- mem_data is Z in every state except a write's LAUNCH/WAIT_BUSY/WAIT_DONE.

Test Plan:
- Reset with host_valid=1, rdyn=0 -> mrdn=mwrdn=1, mem_data=Z, fifo_level=0, no pop during reset; after rst drops, host_ready=1.
- Single write (addr=20'h12345, wdata=16'hA5C3, bhen=0); model rdyn goes 1 for 10 cycles, then 0 -> mwrdn low exactly 3 cycles, mem_data=A5C3 held until rdyn falls, mem_addr=12345, no host_rvalid.
- Single read of addr 20'h00ABC; model drives 16'hBEEF when rdyn falls -> one host_rvalid pulse with host_rdata=BEEF, host_rerr=0; mrdn low 3 cycles.
- Push 5 writes back-to-back with rdyn held 1 -> host_ready drops after 4 accepted, fifo_level=4, 5th held until rdyn releases; all 5 appear at controller in order.
- Read with rdyn stuck 0 for TIMEOUT=16 cycles -> timeout_err=1, host_rvalid pulse with host_rerr=1, host_rdata=0; err_clr asserted in the same cycle as a fresh set -> flag remains 1.
- Interleaved W,R,W,R with distinct data -> read responses in order, mem_data never driven during read phases, strobes never simultaneously low.
